// File: rtl/vector_pkg.sv
// ----------------------------------------------------------------------------
// vector_pkg
//   Shared definitions for the vector point-stream link, used by both the
//   transmit encoder (point_tx) and the point receive buffer.
//
//   point_t     : one 25-bit vector point {draw, x[11:0], y[11:0]}
//   POINT_BYTES : bytes per point on the wire
//   EOF_BYTE    : end-of-frame marker byte (sent POINT_BYTES times)
//   pack_point  : point -> 32-bit wire word {7'b0, point}
//   word_byte   : byte idx of a wire word, MSB-first (idx 0 = bits 31:24)
//   xor_bytes   : XOR of the four bytes of a wire word
// ----------------------------------------------------------------------------
package vector_pkg;

  typedef struct packed {
    logic        draw;  // 1 = draw to (x, y), 0 = jump to (x, y)
    logic [11:0] x;
    logic [11:0] y;
  } point_t;

  localparam int         POINT_BYTES = 4;
  localparam logic [7:0] EOF_BYTE    = 8'hFF;

  // Byte 0 of a packed point is at most 8'h01, so a run of EOF_BYTE can
  // never be mistaken for point data by the receiver.
  function automatic logic [31:0] pack_point(input point_t p);
    return {7'b0, p};
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w,
                                           input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte
//   8N1 UART byte serialiser: start bit (0), data bits 0..7 LSB first,
//   stop bit (1). Every bit is held exactly CLKS_PER_BIT cycles. A new byte
//   may be started in the final cycle of the previous stop bit, so that
//   consecutive bytes are contiguous on the line.
//
//   Parameters : CLKS_PER_BIT - clock cycles per bit (>= 2)
//   Ports      : clk, reset_n (async, active-low)
//                start    - load data and begin a byte (honoured when idle
//                           or in the final stop-bit cycle)
//                data     - byte to send
//                tx       - registered UART line, idle high
//                busy     - a byte is on the line
//                pre_done - one cycle before the final stop-bit cycle
//                done     - final cycle of the stop bit
// ----------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       pre_done,
  output logic       done
);

  localparam int             CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]     BIT_STOP  = 4'd9;

  logic          active_q, active_d;
  logic [3:0]    bit_q,    bit_d;     // 0 = start, 1..8 = data, 9 = stop
  logic [CW-1:0] baud_q,   baud_d;
  logic [7:0]    shift_q,  shift_d;
  logic          tx_q,     tx_d;
  logic          load;

  assign done     = active_q && (bit_q == BIT_STOP) && (baud_q == BAUD_LAST);
  assign pre_done = active_q && (bit_q == BIT_STOP) && (baud_q == BAUD_PRE);
  assign busy     = active_q;
  assign tx       = tx_q;
  assign load     = start && (!active_q || done);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    active_d = active_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    shift_d  = shift_q;
    tx_d     = tx_q;

    if (load) begin
      active_d = 1'b1;
      bit_d    = 4'd0;
      baud_d   = '0;
      shift_d  = data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == BIT_STOP) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            tx_d = 1'b1;                     // entering the stop bit
          end else begin
            tx_d    = shift_q[0];            // next data bit, LSB first
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      baud_q   <= '0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;                      // line idles high, even mid-byte
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/point_tx.sv
// ----------------------------------------------------------------------------
// point_tx
//   Serialises 25-bit vector points into UART bytes using the point-stream
//   framing: each point is sent as the 32-bit word {7'b0, point}, MSB-first
//   (4 bytes). After a point flagged last, four EOF_BYTE marker bytes close
//   the frame.
//
//   Optional feature (macro POINT_TX_CHECKSUM_EN): a running 8-bit XOR of all
//   point bytes of the frame is appended as one byte after the marker and then
//   cleared. Without the macro there is no checksum state or register.
//
//   Parameters : CLKS_PER_BIT - clock cycles per UART bit (>= 2)
//   Ports      : clk, reset_n (async, active-low)
//                in_valid / in_ready - point handshake
//                in_point            - {draw, x[11:0], y[11:0]}
//                in_last             - point closes the frame
//                tx                  - UART line, 8N1, idle high
//                busy                - frame bytes in flight or queued
//                frame_done          - one-cycle pulse at frame end
// ----------------------------------------------------------------------------
module point_tx
  import vector_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_point,
  input  logic        in_last,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_POINT = 2'd1;
  localparam logic [1:0] S_MARK  = 2'd2;
`ifdef POINT_TX_CHECKSUM_EN
  localparam logic [1:0] S_CSUM  = 2'd3;
`endif

  logic [1:0] state_q,      state_d;
  logic [1:0] idx_q,        idx_d;        // byte index within POINT / MARK
  point_t     point_q,      point_d;
  logic       last_q,       last_d;
  logic       ready_en_q,   ready_en_d;   // holds in_ready low until after reset
  logic       frame_done_q, frame_done_d;
`ifdef POINT_TX_CHECKSUM_EN
  logic [7:0] csum_q,       csum_d;
`endif

  logic       accept;
  logic       uart_start;
  logic [7:0] uart_data;
  logic       uart_busy;
  logic       uart_pre_done;
  logic       uart_done;

  assign in_ready   = ready_en_q && (state_q == S_IDLE);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

  // The byte index advances one cycle before the current stop bit ends, so
  // the next byte is queued into the serialiser in that stop bit's final
  // cycle (contiguous bytes), and the return to IDLE leaves exactly one idle
  // line cycle before a back-to-back point's start bit.
  assign uart_start = (state_q != S_IDLE) && (!uart_busy || uart_done);

  always_comb begin
    uart_data = 8'h00;
    case (state_q)
      S_POINT: uart_data = word_byte(pack_point(point_q), idx_q);
      S_MARK:  uart_data = EOF_BYTE;
`ifdef POINT_TX_CHECKSUM_EN
      S_CSUM:  uart_data = csum_q;
`endif
      default: uart_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    point_d      = point_q;
    last_d       = last_q;
    ready_en_d   = 1'b1;
    frame_done_d = 1'b0;
`ifdef POINT_TX_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          point_d = in_point;
          last_d  = in_last;
          idx_d   = 2'd0;
          state_d = S_POINT;
`ifdef POINT_TX_CHECKSUM_EN
          csum_d  = csum_q ^ xor_bytes(pack_point(in_point));
`endif
        end
      end
      S_POINT: begin
        if (uart_pre_done) begin
          if (idx_q == 2'(POINT_BYTES - 1)) begin
            idx_d   = 2'd0;
            state_d = last_q ? S_MARK : S_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_MARK: begin
        if (uart_pre_done) begin
          if (idx_q == 2'(POINT_BYTES - 1)) begin
            idx_d = 2'd0;
`ifdef POINT_TX_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
`ifdef POINT_TX_CHECKSUM_EN
      S_CSUM: begin
        if (uart_pre_done) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          csum_d       = 8'h00;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      point_q      <= '0;
      last_q       <= 1'b0;
      ready_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef POINT_TX_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      point_q      <= point_d;
      last_q       <= last_d;
      ready_en_q   <= ready_en_d;
      frame_done_q <= frame_done_d;
`ifdef POINT_TX_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (uart_start),
    .data     (uart_data),
    .tx       (tx),
    .busy     (uart_busy),
    .pre_done (uart_pre_done),
    .done     (uart_done)
  );

endmodule

// File: tb/tb_point_tx.sv
// ----------------------------------------------------------------------------
// tb_point_tx
//   Self-checking bench for point_tx with CLKS_PER_BIT = 4. The reference
//   model builds the expected byte list of each transaction from the framing
//   rules and derives the exact expected line waveform and handshake timing
//   from it. Build with +define+POINT_TX_CHECKSUM_EN to cover the checksum.
// ----------------------------------------------------------------------------
module tb_point_tx;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_point;
  logic        in_last;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int         tests    = 0;
  int         fails    = 0;
  logic [7:0] csum_acc = 8'h00;

  always #5 clk = ~clk;

  point_tx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_point   (in_point),
    .in_last    (in_last),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge while in_ready should be high. Presents point p,
  // lets it be accepted, then follows every cycle of the transaction. With
  // hold set, in_valid stays high and p_next/last_next are presented while
  // the block is busy; the call returns at the falling edge where the next
  // point should be taken.
  task automatic send_point(input logic [24:0] p, input bit last,
                            input bit hold, input logic [24:0] p_next,
                            input bit last_next);
    logic [7:0] eb[$];
    logic [31:0] w;
    logic        tx_s[];
    logic        e;
    logic [7:0]  d;
    int          L, off, b, pos;
    int          wave_err, rdy_err, fd_err, busy_err;
    wave_err = 0; rdy_err = 0; fd_err = 0; busy_err = 0;

    w = {7'b0, p};
    for (int i = 0; i < 4; i++) begin
      eb.push_back(w[31-8*i -: 8]);
      csum_acc = csum_acc ^ w[31-8*i -: 8];
    end
    if (last) begin
      for (int i = 0; i < 4; i++) eb.push_back(8'hFF);
`ifdef POINT_TX_CHECKSUM_EN
      eb.push_back(csum_acc);
      csum_acc = 8'h00;
`endif
    end
    L = eb.size() * 10 * N;

    in_valid = 1'b1;
    in_point = p;
    in_last  = last;
    check("ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    if (hold) begin
      in_point = p_next;
      in_last  = last_next;
    end else begin
      in_valid = 1'b0;
      in_point = 25'($urandom);
      in_last  = 1'($urandom);
    end

    tx_s = new[L + 2];
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      tx_s[c] = tx;
      if (c == 1) e = 1'b1;
      else begin
        off = c - 2;
        b   = off / (10 * N);
        pos = (off % (10 * N)) / N;
        if (pos == 0)      e = 1'b0;
        else if (pos == 9) e = 1'b1;
        else               e = eb[b][pos-1];
      end
      if (tx !== e) wave_err++;
      if (in_ready !== (c == L + 1)) rdy_err++;
      if (frame_done !== (last && c == L + 1)) fd_err++;
      if (c <= L && busy !== 1'b1) busy_err++;
    end
    check("tx_waveform_errors", wave_err, 0);
    check("in_ready_timing_errors", rdy_err, 0);
    check("frame_done_timing_errors", fd_err, 0);
    check("busy_errors", busy_err, 0);
    for (int k = 0; k < eb.size(); k++) begin
      for (int j = 0; j < 8; j++) d[j] = tx_s[2 + k*10*N + (j+1)*N + N/2];
      check($sformatf("byte%0d", k), d, eb[k]);
    end

    if (!hold) begin
      @(negedge clk);
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
      check("idle_frame_done", frame_done, 0);
      check("idle_ready", in_ready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] pts[4];
    int          errs, np;
    bit          hold;

    // Reset behaviour
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_point = 25'd0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", in_ready, 0);
    check("reset_frame_done", frame_done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", in_ready, 1);

    // Idle line must stay high with no spurious activity
    errs = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
    end
    check("idle_glitches", errs, 0);

    // Directed frames
    send_point(25'h1ABC123, 1'b0, 1'b0, 25'd0, 1'b0);
    send_point(25'h0000FFF, 1'b1, 1'b0, 25'd0, 1'b0);
    send_point(25'h1ABC123, 1'b1, 1'b0, 25'd0, 1'b0);
    send_point(25'h0000FFF, 1'b1, 1'b0, 25'd0, 1'b0);

    // Back-to-back: in_valid held high across three points
    for (int i = 0; i < 3; i++) pts[i] = 25'($urandom);
    send_point(pts[0], 1'b0, 1'b1, pts[1], 1'b0);
    send_point(pts[1], 1'b0, 1'b1, pts[2], 1'b1);
    send_point(pts[2], 1'b1, 1'b0, 25'd0, 1'b0);

    // Random frames of 1-3 points, randomly back-to-back or spaced
    for (int f = 0; f < 4; f++) begin
      np   = $urandom_range(1, 3);
      hold = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) pts[i] = 25'($urandom);
      for (int i = 0; i < np; i++)
        send_point(pts[i], (i == np - 1), hold && (i < np - 1),
                   pts[i+1], (i + 1 == np - 1));
      if (!hold) repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Reset in the middle of byte 1 (bytes 01 00 00 00: line low there)
    in_valid = 1'b1;
    in_point = 25'h1000000;
    in_last  = 1'b1;
    check("ready_before_abort", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2 + 14 * N + 2) @(negedge clk);
    check("tx_low_mid_byte1", tx, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_tx_forced_high", tx, 1);
    check("abort_ready_low", in_ready, 0);
    check("abort_busy_low", busy, 0);
    csum_acc = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", in_ready, 1);
    errs = 0;
    repeat (30 * N) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("no_partial_resend", errs, 0);
    send_point(25'h0000FFF, 1'b1, 1'b0, 25'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
